// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared definitions for the two-source round-robin output arbiter.
//   state_e : output-stage occupancy (EMPTY / FULL)
//   SRC0/1  : encoding of the winning source, as reported on out_src
package mux2_rr_arbiter_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

endpackage

// File: rtl/mux_2_to_1.sv
// Plain WIDTH-bit 2:1 data mux.
//   sel_i  : 0 selects in0_i, 1 selects in1_i
//   in0_i  : data leg 0
//   in1_i  : data leg 1
//   y_o    : selected word, passed through unchanged
module mux_2_to_1 #(
  parameter int WIDTH = 32
) (
  input  logic             sel_i,
  input  logic [WIDTH-1:0] in0_i,
  input  logic [WIDTH-1:0] in1_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = sel_i ? in1_i : in0_i;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing one registered WIDTH-bit output channel between
// two valid/ready producers. One word per cycle with out_ready held high.
//   clk, rst          : clock, async active-high reset
//   in0_valid/in0     : source 0 request and data;  in0_ready : source 0 accepted
//   in1_valid/in1     : source 1 request and data;  in1_ready : source 1 accepted
//   out_valid/out     : output stage occupancy and held word
//   out_src           : which source the held word came from
//   out_ready         : consumer takes the held word
module mux2_rr_arbiter
  import mux2_rr_arbiter_pkg::*;
#(
  parameter int   WIDTH     = 32,
  parameter logic INIT_LAST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_src,
  input  logic             out_ready
);

  state_e           state_q;
  logic [WIDTH-1:0] data_q;
  logic             src_q;
  logic             last_q;

  logic             any_valid;
  logic             gnt;
  logic             load_en;
  logic             accept;
  logic [WIDTH-1:0] mux_d;

  assign any_valid = in0_valid | in1_valid;

  // On a tie the source that did not win last time goes first.
  always_comb begin
    gnt = SRC0;
    if (in0_valid && in1_valid) gnt = ~last_q;
    else if (in1_valid)         gnt = SRC1;
  end

  // Stage can take a word when empty or when its current word leaves this cycle.
  assign load_en = (state_q == ST_EMPTY) | out_ready;
  assign accept  = load_en & any_valid;

  // rst gates the readys so nothing looks accepted while the stage is held clear.
  assign in0_ready = ~rst & load_en & in0_valid & (gnt == SRC0);
  assign in1_ready = ~rst & load_en & in1_valid & (gnt == SRC1);

  mux_2_to_1 #(.WIDTH(WIDTH)) u_mux (
    .sel_i (gnt),
    .in0_i (in0),
    .in1_i (in1),
    .y_o   (mux_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      src_q   <= SRC0;
      last_q  <= INIT_LAST;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (any_valid) begin
            state_q <= ST_FULL;
            data_q  <= mux_d;
            src_q   <= gnt;
            last_q  <= gnt;
          end
        end
        ST_FULL: begin
          // Drain and refill on the same edge; no bubble. A stall freezes everything.
          if (out_ready) begin
            if (any_valid) begin
              data_q <= mux_d;
              src_q  <= gnt;
              last_q <= gnt;
            end else begin
              state_q <= ST_EMPTY;
            end
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out       = data_q;
  assign out_src   = src_q;

  // accept is folded into the state machine above; kept for readability of the grant path.
  logic unused_accept;
  assign unused_accept = accept;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
module tb_mux2_rr_arbiter;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             in0_valid, in1_valid;
  logic [WIDTH-1:0] in0, in1;
  logic             in0_ready, in1_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out;
  logic             out_src;
  logic             out_ready;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux2_rr_arbiter #(.WIDTH(WIDTH), .INIT_LAST(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_valid (in0_valid),
    .in0       (in0),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1       (in1),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out       (out),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Producer contract: a pending (valid & !ready) word must be held unchanged.
  logic             pend0 = 1'b0, pend1 = 1'b0;
  logic [WIDTH-1:0] hold0 = '0, hold1 = '0;
  always @(posedge clk) begin
    if (!rst && pend0) assert (in0_valid && in0 == hold0) else $error("src0 dropped pending word");
    if (!rst && pend1) assert (in1_valid && in1 == hold1) else $error("src1 dropped pending word");
    pend0 <= in0_valid & ~in0_ready & ~rst;
    pend1 <= in1_valid & ~in1_ready & ~rst;
    hold0 <= in0;
    hold1 <= in1;
  end

  initial begin
    // 1 reset with both sources requesting
    rst = 1'b1; in0_valid = 1'b1; in1_valid = 1'b1;
    in0 = 32'h7; in1 = 32'h3; out_ready = 1'b1;
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_in0_ready", in0_ready, 0);
    chk("rst_in1_ready", in1_ready, 0);
    rst = 1'b0;
    #1;
    chk("first_tie_in0_ready", in0_ready, 1);
    chk("first_tie_in1_ready", in1_ready, 0);

    // 3 tie fairness: 7,3,7,3
    for (int i = 0; i < 4; i++) begin
      step();
      chk("tie_out", out, (i % 2 == 0) ? 32'h7 : 32'h3);
      chk("tie_src", out_src, (i % 2 == 0) ? 0 : 1);
    end
    // serve the pending src0 word before switching data
    in1_valid = 1'b0;
    step();
    chk("tie_tail_out", out, 32'h7);

    // 2 single source
    in0 = 32'h2;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("single_out", out, 32'h2);
      chk("single_src", out_src, 0);
      chk("single_in1_ready", in1_ready, 0);
      chk("single_valid", out_valid, 1);
    end

    // 4 backpressure with src1 word held
    in0_valid = 1'b0; in1_valid = 1'b1; in1 = 32'h4;
    step();
    chk("bp_load_out", out, 32'h4);
    chk("bp_load_src", out_src, 1);
    out_ready = 1'b0; in0_valid = 1'b1; in0 = 32'h9; in1 = 32'h5;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in0_ready", in0_ready, 0);
      chk("bp_in1_ready", in1_ready, 0);
      step();
      chk("bp_out", out, 32'h4);
      chk("bp_src", out_src, 1);
      chk("bp_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in0_ready", in0_ready, 1);
    chk("bp_release_in1_ready", in1_ready, 0);
    step();
    chk("bp_release_out", out, 32'h9);
    chk("bp_release_src", out_src, 0);
    // let the pending src1 word through
    in0_valid = 1'b0;
    step();
    chk("bp_tail_out", out, 32'h5);
    chk("bp_tail_src", out_src, 1);

    // 5 drain to empty
    in1_valid = 1'b0;
    step();
    chk("drain_valid", out_valid, 0);
    chk("drain_out", out, 32'h5);
    chk("drain_src", out_src, 1);
    step();
    chk("idle_valid", out_valid, 0);

    // 6 async reset while stalled
    in0_valid = 1'b1; in0 = 32'h6;
    step();
    chk("mid_load_out", out, 32'h6);
    in0_valid = 1'b0; out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_out", out, 0);
    chk("mid_rst_src", out_src, 0);
    rst = 1'b0;
    in0_valid = 1'b1; in1_valid = 1'b1; in0 = 32'hA; in1 = 32'hB; out_ready = 1'b1;
    #1;
    // last was src0 before reset; reset puts it back to INIT_LAST so src0 wins again
    chk("post_rst_in0_ready", in0_ready, 1);
    chk("post_rst_in1_ready", in1_ready, 0);
    step();
    chk("post_rst_out", out, 32'hA);
    in0_valid = 1'b0;
    step();
    chk("post_rst_out2", out, 32'hB);
    in1_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
